// File: rtl/ball_motion.sv
// Per-frame ball position generator: steps every ball once per vertical sync with
// wall reflection, computing into shadow registers and committing all balls at once.
module ball_motion #(
  parameter int NUM_BALLS     = 2,
  parameter int BALL_SPEED    = 5,
  parameter int BALL_RADIUS   = 25,
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int START_X       = 150,
  parameter int START_Y       = 100,
  parameter int STEP_X        = 200,
  parameter int STEP_Y        = 120
) (
  input  logic                     clk_100mhz,
  input  logic                     reset_n,
  input  logic                     v_sync,
  input  logic                     pause,
  output logic [10*NUM_BALLS-1:0]  ball_x,
  output logic [10*NUM_BALLS-1:0]  ball_y,
  output logic                     busy,
  output logic                     frame_done,
  output logic [15:0]              frame_count
);

  localparam logic [10:0] X_MIN = 11'(BALL_RADIUS);
  localparam logic [10:0] X_MAX = 11'(SCREEN_WIDTH - 1 - BALL_RADIUS);
  localparam logic [10:0] Y_MIN = 11'(BALL_RADIUS);
  localparam logic [10:0] Y_MAX = 11'(SCREEN_HEIGHT - 1 - BALL_RADIUS);
  localparam logic [10:0] SPEED = 11'(BALL_SPEED);
  localparam int          IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    COMMIT
  } state_t;

  // One axis step; returns {new direction, new position}, clamped exactly to the walls.
  function automatic logic [10:0] stepAxis(input logic [9:0] p, input logic v,
                                           input logic [10:0] lo, input logic [10:0] hi);
    logic [10:0] w_sum;
    logic [10:0] w_res;
    w_sum = '0;
    if (v) begin
      w_sum = {1'b0, p} + SPEED;
      if (w_sum >= hi) w_res = {1'b0, 10'(hi)};
      else             w_res = {1'b1, w_sum[9:0]};
    end else begin
      if ({1'b0, p} <= lo + SPEED) begin
        w_res = {1'b1, 10'(lo)};
      end else begin
        w_sum = {1'b0, p} - SPEED;
        w_res = {1'b0, w_sum[9:0]};
      end
    end
    return w_res;
  endfunction

  state_t                  r_state;
  state_t                  w_nextState;
  logic                    r_vsD;
  logic                    w_tick;
  logic [IDX_W-1:0]        r_idx;
  logic [9:0]              r_shadowX [NUM_BALLS];
  logic [9:0]              r_shadowY [NUM_BALLS];
  logic [NUM_BALLS-1:0]    r_vx;
  logic [NUM_BALLS-1:0]    r_vy;
  logic [10*NUM_BALLS-1:0] r_ballX;
  logic [10*NUM_BALLS-1:0] r_ballY;
  logic                    r_frameDone;
  logic [15:0]             r_frameCount;
  logic [9:0]              w_curX;
  logic [9:0]              w_curY;
  logic                    w_curVx;
  logic                    w_curVy;
  logic [10:0]             w_stepX;
  logic [10:0]             w_stepY;

  assign w_tick = r_vsD & ~v_sync;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_tick && !pause) w_nextState = UPDATE;
      UPDATE:  if (r_idx == LAST_IDX) w_nextState = COMMIT;
      COMMIT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_vsD        <= 1'b1;
      r_idx        <= '0;
      r_frameDone  <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_state     <= w_nextState;
      r_vsD       <= v_sync;
      r_frameDone <= (r_state == COMMIT);
      if (r_state == COMMIT) r_frameCount <= r_frameCount + 16'd1;
      if (r_state == UPDATE) r_idx <= r_idx + 1'b1;
      else                   r_idx <= '0;
    end
  end

  // A single stepper is shared by all balls; the current index selects its operands.
  always_comb begin
    w_curX  = '0;
    w_curY  = '0;
    w_curVx = 1'b0;
    w_curVy = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_curX  = r_shadowX[i];
        w_curY  = r_shadowY[i];
        w_curVx = r_vx[i];
        w_curVy = r_vy[i];
      end
    end
  end

  assign w_stepX = stepAxis(w_curX, w_curVx, X_MIN, X_MAX);
  assign w_stepY = stepAxis(w_curY, w_curVy, Y_MIN, Y_MAX);

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        r_shadowX[i] <= 10'(START_X + i * STEP_X);
        r_shadowY[i] <= 10'(START_Y + i * STEP_Y);
        r_vx[i]      <= ~i[0];
        r_vy[i]      <= 1'b1;
      end
    end else if (r_state == UPDATE) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (r_idx == IDX_W'(i)) begin
          r_shadowX[i] <= w_stepX[9:0];
          r_shadowY[i] <= w_stepY[9:0];
          r_vx[i]      <= w_stepX[10];
          r_vy[i]      <= w_stepY[10];
        end
      end
    end
  end

  // Visible coordinates move only on commit so the renderer sees one frame-constant set.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        r_ballX[10*i +: 10] <= 10'(START_X + i * STEP_X);
        r_ballY[10*i +: 10] <= 10'(START_Y + i * STEP_Y);
      end
    end else if (r_state == COMMIT) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        r_ballX[10*i +: 10] <= r_shadowX[i];
        r_ballY[10*i +: 10] <= r_shadowY[i];
      end
    end
  end

  assign ball_x      = r_ballX;
  assign ball_y      = r_ballY;
  assign busy        = (r_state != IDLE);
  assign frame_done  = r_frameDone;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: default configuration plus two small instances
// placed near the walls to reach the reflection cases within a few frames.
module tb_ball_motion;

  logic        clk = 1'b0;
  logic        resetN;
  logic        vSync, vSync2, vSync3;
  logic        pause;
  logic [19:0] ballX, ballY;
  logic        busy, frameDone;
  logic [15:0] frameCount;
  logic [9:0]  ballX2, ballY2;
  logic        busy2, frameDone2;
  logic [15:0] frameCount2;
  logic [19:0] ballX3, ballY3;
  logic        busy3, frameDone3;
  logic [15:0] frameCount3;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk_100mhz(clk), .reset_n(resetN), .v_sync(vSync), .pause(pause),
    .ball_x(ballX), .ball_y(ballY), .busy(busy), .frame_done(frameDone),
    .frame_count(frameCount)
  );

  ball_motion #(.NUM_BALLS(1), .START_X(770), .START_Y(570)) dutRight (
    .clk_100mhz(clk), .reset_n(resetN), .v_sync(vSync2), .pause(1'b0),
    .ball_x(ballX2), .ball_y(ballY2), .busy(busy2), .frame_done(frameDone2),
    .frame_count(frameCount2)
  );

  ball_motion #(.NUM_BALLS(2), .START_X(33), .STEP_X(0)) dutLeft (
    .clk_100mhz(clk), .reset_n(resetN), .v_sync(vSync3), .pause(1'b0),
    .ball_x(ballX3), .ball_y(ballY3), .busy(busy3), .frame_done(frameDone3),
    .frame_count(frameCount3)
  );

  // One-cycle low pulse on the selected instance's v_sync, then idle long enough to commit.
  task automatic pulseSync(input int which, input int waitCycles);
    @(negedge clk);
    case (which)
      1:       vSync  = 1'b0;
      2:       vSync2 = 1'b0;
      default: vSync3 = 1'b0;
    endcase
    @(negedge clk);
    vSync = 1'b1; vSync2 = 1'b1; vSync3 = 1'b1;
    repeat (waitCycles) @(negedge clk);
  endtask

  task automatic test_reset;
    vectors++; if (ballX !== {10'd350, 10'd150}) begin miscompares++; $display("[TB] FAIL reset_ball_x: got %h expected %h", ballX, {10'd350, 10'd150}); end
    vectors++; if (ballY !== {10'd220, 10'd100}) begin miscompares++; $display("[TB] FAIL reset_ball_y: got %h expected %h", ballY, {10'd220, 10'd100}); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frameDone); end
    vectors++; if (frameCount !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_frame_count: got %0d expected 0", frameCount); end
    vectors++; if (ballX2 !== 10'd770) begin miscompares++; $display("[TB] FAIL reset_right_x: got %0d expected 770", ballX2); end
    vectors++; if (ballX3 !== {10'd33, 10'd33}) begin miscompares++; $display("[TB] FAIL reset_left_x: got %h expected %h", ballX3, {10'd33, 10'd33}); end
  endtask

  task automatic test_first_frame;
    @(negedge clk);
    vSync = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) vSync = 1'b1;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL first_busy_c%0d: got %b expected 1", c, busy); end
      vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("[TB] FAIL first_done_c%0d: got %b expected 0", c, frameDone); end
      vectors++; if (ballX !== {10'd350, 10'd150}) begin miscompares++; $display("[TB] FAIL first_stable_x_c%0d: got %h expected %h", c, ballX, {10'd350, 10'd150}); end
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL first_busy_c4: got %b expected 0", busy); end
    vectors++; if (frameDone !== 1'b1) begin miscompares++; $display("[TB] FAIL first_done_c4: got %b expected 1", frameDone); end
    vectors++; if (ballX !== {10'd345, 10'd155}) begin miscompares++; $display("[TB] FAIL first_ball_x: got %h expected %h", ballX, {10'd345, 10'd155}); end
    vectors++; if (ballY !== {10'd225, 10'd105}) begin miscompares++; $display("[TB] FAIL first_ball_y: got %h expected %h", ballY, {10'd225, 10'd105}); end
    vectors++; if (frameCount !== 16'd1) begin miscompares++; $display("[TB] FAIL first_count: got %0d expected 1", frameCount); end
    @(negedge clk);
    vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("[TB] FAIL first_done_c5: got %b expected 0", frameDone); end
  endtask

  task automatic test_right_wall;
    pulseSync(2, 5);
    vectors++; if (ballX2 !== 10'd774) begin miscompares++; $display("[TB] FAIL right_clamp_x: got %0d expected 774", ballX2); end
    vectors++; if (ballY2 !== 10'd574) begin miscompares++; $display("[TB] FAIL bottom_clamp_y: got %0d expected 574", ballY2); end
    pulseSync(2, 5);
    vectors++; if (ballX2 !== 10'd769) begin miscompares++; $display("[TB] FAIL right_reflect_x: got %0d expected 769", ballX2); end
    vectors++; if (ballY2 !== 10'd569) begin miscompares++; $display("[TB] FAIL bottom_reflect_y: got %0d expected 569", ballY2); end
    vectors++; if (frameCount2 !== 16'd2) begin miscompares++; $display("[TB] FAIL right_count: got %0d expected 2", frameCount2); end
    vectors++; if (busy2 !== 1'b0 || frameDone2 !== 1'b0) begin miscompares++; $display("[TB] FAIL right_idle: got busy=%b done=%b expected 0/0", busy2, frameDone2); end
  endtask

  task automatic test_left_bounce;
    int expB1[3] = '{28, 25, 30};
    for (int f = 0; f < 3; f++) begin
      pulseSync(3, 5);
      vectors++; if (ballX3[19:10] !== 10'(expB1[f])) begin miscompares++; $display("[TB] FAIL left_b1x_f%0d: got %0d expected %0d", f + 1, ballX3[19:10], expB1[f]); end
    end
    vectors++; if (ballX3[9:0] !== 10'd48) begin miscompares++; $display("[TB] FAIL left_b0x: got %0d expected 48", ballX3[9:0]); end
    vectors++; if (ballY3 !== {10'd235, 10'd115}) begin miscompares++; $display("[TB] FAIL left_ball_y: got %h expected %h", ballY3, {10'd235, 10'd115}); end
    vectors++; if (frameCount3 !== 16'd3) begin miscompares++; $display("[TB] FAIL left_count: got %0d expected 3", frameCount3); end
    vectors++; if (busy3 !== 1'b0 || frameDone3 !== 1'b0) begin miscompares++; $display("[TB] FAIL left_idle: got busy=%b done=%b expected 0/0", busy3, frameDone3); end
  endtask

  task automatic test_long_vsync;
    int pulses = 0;
    @(negedge clk);
    vSync = 1'b0;
    repeat (20) begin @(negedge clk); if (frameDone === 1'b1) pulses++; end
    vSync = 1'b1;
    repeat (10) begin @(negedge clk); if (frameDone === 1'b1) pulses++; end
    vectors++; if (pulses != 1) begin miscompares++; $display("[TB] FAIL long_vsync_pulses: got %0d expected 1", pulses); end
    vectors++; if (frameCount !== 16'd2) begin miscompares++; $display("[TB] FAIL long_vsync_count: got %0d expected 2", frameCount); end
    vectors++; if (ballX !== {10'd340, 10'd160}) begin miscompares++; $display("[TB] FAIL long_vsync_x: got %h expected %h", ballX, {10'd340, 10'd160}); end
    vectors++; if (ballY !== {10'd230, 10'd110}) begin miscompares++; $display("[TB] FAIL long_vsync_y: got %h expected %h", ballY, {10'd230, 10'd110}); end
  endtask

  task automatic test_pause;
    int pulses = 0;
    int busyCycles = 0;
    @(negedge clk);
    pause = 1'b1;
    vSync = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) vSync = 1'b1;
      if (frameDone === 1'b1) pulses++;
      if (busy === 1'b1) busyCycles++;
    end
    pause = 1'b0;
    vectors++; if (pulses != 0 || busyCycles != 0) begin miscompares++; $display("[TB] FAIL pause_activity: got done=%0d busy=%0d expected 0/0", pulses, busyCycles); end
    vectors++; if (frameCount !== 16'd2) begin miscompares++; $display("[TB] FAIL pause_count: got %0d expected 2", frameCount); end
    vectors++; if (ballX !== {10'd340, 10'd160}) begin miscompares++; $display("[TB] FAIL pause_x: got %h expected %h", ballX, {10'd340, 10'd160}); end
  endtask

  task automatic test_late_pause;
    @(negedge clk);
    vSync = 1'b0;
    @(negedge clk);
    vSync = 1'b1;
    pause = 1'b1;
    repeat (5) @(negedge clk);
    pause = 1'b0;
    vectors++; if (frameCount !== 16'd3) begin miscompares++; $display("[TB] FAIL late_pause_count: got %0d expected 3", frameCount); end
    vectors++; if (ballX !== {10'd335, 10'd165}) begin miscompares++; $display("[TB] FAIL late_pause_x: got %h expected %h", ballX, {10'd335, 10'd165}); end
    vectors++; if (ballY !== {10'd235, 10'd115}) begin miscompares++; $display("[TB] FAIL late_pause_y: got %h expected %h", ballY, {10'd235, 10'd115}); end
  endtask

  task automatic test_reset_mid_update;
    @(negedge clk);
    vSync = 1'b0;
    @(negedge clk);
    vSync = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    resetN = 1'b0;
    #1;
    vectors++; if (ballX !== {10'd350, 10'd150}) begin miscompares++; $display("[TB] FAIL mid_reset_x: got %h expected %h", ballX, {10'd350, 10'd150}); end
    vectors++; if (ballY !== {10'd220, 10'd100}) begin miscompares++; $display("[TB] FAIL mid_reset_y: got %h expected %h", ballY, {10'd220, 10'd100}); end
    vectors++; if (busy !== 1'b0 || frameDone !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_ctrl: got busy=%b done=%b expected 0/0", busy, frameDone); end
    vectors++; if (frameCount !== 16'd0) begin miscompares++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", frameCount); end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    pulseSync(1, 5);
    vectors++; if (ballX !== {10'd345, 10'd155}) begin miscompares++; $display("[TB] FAIL after_reset_x: got %h expected %h", ballX, {10'd345, 10'd155}); end
    vectors++; if (ballY !== {10'd225, 10'd105}) begin miscompares++; $display("[TB] FAIL after_reset_y: got %h expected %h", ballY, {10'd225, 10'd105}); end
    vectors++; if (frameCount !== 16'd1) begin miscompares++; $display("[TB] FAIL after_reset_count: got %0d expected 1", frameCount); end
  endtask

  // Many frames: coordinates stay inside the walls and only move on a commit.
  task automatic test_long_run;
    logic [19:0] prevX;
    int          pulses = 0;
    prevX = ballX;
    for (int f = 0; f < 300; f++) begin
      @(negedge clk);
      vSync = 1'b0;
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        if (c == 0) vSync = 1'b1;
        if (frameDone === 1'b1) pulses++;
        for (int b = 0; b < 2; b++) begin
          vectors++;
          if (ballX[10*b +: 10] < 10'd25 || ballX[10*b +: 10] > 10'd774 ||
              ballY[10*b +: 10] < 10'd25 || ballY[10*b +: 10] > 10'd574) begin
            miscompares++;
            $display("[TB] FAIL run_bounds_b%0d: got (%0d,%0d) expected within [25,774]x[25,574]", b, ballX[10*b +: 10], ballY[10*b +: 10]);
          end
        end
        vectors++;
        if (ballX !== prevX && frameDone !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL run_stable_x: got %h expected %h outside commit", ballX, prevX);
        end
        prevX = ballX;
      end
    end
    vectors++; if (pulses != 300) begin miscompares++; $display("[TB] FAIL run_pulses: got %0d expected 300", pulses); end
    vectors++; if (frameCount !== 16'd301) begin miscompares++; $display("[TB] FAIL run_count: got %0d expected 301", frameCount); end
  endtask

  initial begin
    resetN = 1'b0;
    vSync  = 1'b1;
    vSync2 = 1'b1;
    vSync3 = 1'b1;
    pause  = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_right_wall();
    test_left_bounce();
    test_long_vsync();
    test_pause();
    test_late_pause();
    test_reset_mid_update();
    test_long_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Per-frame ball position generator feeding the metaball renderer. Holds centre coordinates and direction bits for `NUM_BALLS` balls, detects the start of vertical sync from the VGA timing stage, and steps every ball by `BALL_SPEED` once per frame with wall reflection. Positions are computed into shadow registers and committed atomically, so the renderer's distance evaluation sees constant coordinates for a whole frame. All logic runs on the pixel-timing clock; no logic is clocked from `v_sync`.

## Interface
- `NUM_BALLS`, 2: number of balls. Legal range is 1 to 4.
- `BALL_SPEED`, 5: pixels moved per axis per frame. Legal range is 1 to 15.
- `BALL_RADIUS`, 25: margin from each screen edge to the ball centre.
- `SCREEN_WIDTH`, 800 / `SCREEN_HEIGHT`, 600: visible area.
- `START_X`, 150 / `START_Y`, 100: reset centre of ball 0.
- `STEP_X`, 200 / `STEP_Y`, 120: reset offset per ball index. Ball i starts at (`START_X`+i·`STEP_X`, `START_Y`+i·`STEP_Y`). Every start point must lie within the legal range (see Operation).
- `clk_100mhz` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `v_sync` in 1: active-low vertical sync from the VGA timing stage. It is synchronous to `clk_100mhz`.
- `pause` in 1: when high, frame ticks are ignored.
- `ball_x` out 10·NUM_BALLS: packed centre x coordinates. Ball i occupies `[10i+9:10i]`.
- `ball_y` out 10·NUM_BALLS: packed centre y coordinates, same packing.
- `busy` out 1: high while an update is in progress.
- `frame_done` out 1: one-cycle pulse when new positions are committed.
- `frame_count` out 16: number of committed updates. Wraps from 0xFFFF to 0.

## Operation
- Legal range:
  - X_MIN = `BALL_RADIUS`; X_MAX = `SCREEN_WIDTH`−1−`BALL_RADIUS`. Defaults are 25 and 774.
  - Y_MIN = `BALL_RADIUS`; Y_MAX = `SCREEN_HEIGHT`−1−`BALL_RADIUS`. Defaults are 25 and 574.
- Reset direction: vx_i = ~i[0] (1 means increasing), vy_i = 1.
- Frame tick:
  - `vs_d` is a register holding the previous `v_sync`; it resets to 1.
  - tick = `vs_d` & ~`v_sync`, i.e. the first cycle `v_sync` is sampled low.
  - If `v_sync` is low at reset release, one tick occurs in the first cycle.
- FSM states: IDLE, UPDATE, COMMIT.
  - IDLE → UPDATE on tick & ~`pause`. The ball index is set to 0.
  - UPDATE processes ball `idx` in one cycle, writing shadow x, y, vx and vy. It increments `idx`; after ball `NUM_BALLS`−1 it goes to COMMIT.
  - COMMIT copies shadow registers to `ball_x`/`ball_y`, pulses `frame_done`, increments `frame_count`, then returns to IDLE.
- Per-axis step, applied to each axis independently. Use 11-bit arithmetic; no wrap is permitted.
  - v=1: n = p + S. If n ≥ MAX, then p ← MAX and v ← 0; otherwise p ← n.
  - v=0: if p ≤ MIN + S, then p ← MIN and v ← 1; otherwise p ← p − S.
- Positions are clamped exactly to MIN/MAX and never leave the range.
- Direction bits live only in the shadow state. Shadow state starts equal to the reset positions.
- `ball_x`/`ball_y` change only in COMMIT and are stable during UPDATE.
- Ticks arriving while not in IDLE are ignored. With a 666-line frame this cannot occur in practice.
- A tick with `pause` high is dropped: no update, no `frame_done`, no count change.
- `pause` sampled after the IDLE→UPDATE transition has no effect on that update.
- Asserting `reset_n` low at any time, including mid-UPDATE, immediately returns:
  - all state to IDLE;
  - shadow and output positions to start values;
  - directions to reset values;
  - `frame_count` to 0, `busy` to 0, `frame_done` to 0.

## Timing
- Cycle 0 is the cycle in which tick is asserted.
- `busy` is high in cycles 1 to `NUM_BALLS`+1.
- Ball i is processed in cycle 1+i.
- COMMIT occurs in cycle `NUM_BALLS`+1. New `ball_x`/`ball_y`/`frame_count` and `frame_done`=1 are visible in cycle `NUM_BALLS`+2. This is 4 cycles for the defaults.
- `frame_done` is high for exactly one cycle per committed update.
- Positions are updated during the sync pulse, well before the first visible line of the next frame.

## Test plan
- Reset with defaults → `ball_x` = {350,150}, `ball_y` = {220,100}, `busy`=0, `frame_count`=0. Drive `v_sync` 1→0 → `busy` high for 3 cycles, `frame_done` pulse in cycle 4, ball0 = (155,105), ball1 = (345,225), `frame_count`=1.
- Right-wall bounce: `NUM_BALLS`=1, `START_X`=770 with vx=1 (index 0) → after frame 1 x=774 and vx=0; after frame 2 x=769.
- Left/top bounce:
  - ball1 is driven until x = 28 while moving left; next frame gives x=25, and the frame after gives x=30.
  - y bottom clamp: 570 → 574, and the frame after gives 569.
- Hold `v_sync` low for 10 lines, then high → exactly one update. Pulse `pause` high across a tick → positions, `frame_count` and `frame_done` unchanged.
- Assert `reset_n` low in cycle 2 of an update → outputs return immediately to the reset values. The next tick yields (155,105) for ball0.
- Run 65,536 frames → `frame_count` wraps to 0. Every ball coordinate stays within [25,774]×[25,574] throughout, and `ball_x` never changes while `busy`=0 except in the commit cycle.
